// File: rtl/nmcu_writeback_if.sv
// rtl/nmcu_writeback_if.sv - control, local-buffer read and memory handshake signals of the writeback stage
interface nmcu_writeback_if #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATABUS_WIDTH = 32,
  parameter int DW            = 5
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic [ADDR_WIDTH-1:0]    output_addr;
  logic [DW-1:0]            out_width;
  logic [DW-1:0]            out_height;
  logic [DW-1:0]            full_output_width;
  logic [DW-2:0]            rd_row;
  logic [DW-2:0]            rd_col;
  logic [DATABUS_WIDTH-1:0] rd_data;
  logic                     mem_sel;
  logic                     mem_w;
  logic                     ready;

  // Writeback engine side
  modport master (
    input  start, output busy, output done,
    input  output_addr, input out_width, input out_height, input full_output_width,
    output rd_row, output rd_col, input rd_data,
    output mem_sel, output mem_w, input ready
  );

  // Controller / buffer / memory side
  modport slave (
    output start, input busy, input done,
    output output_addr, output out_width, output out_height, output full_output_width,
    input  rd_row, input rd_col, output rd_data,
    input  mem_sel, input mem_w, output ready
  );
endinterface

// File: rtl/nmcu_writeback.sv
// rtl/nmcu_writeback.sv - drains the local activation cone to global memory; optional NMCU_WB_FUSED_RELU_EN
module nmcu_writeback #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATABUS_WIDTH = 32,
  parameter int MAX_INPUT_DIM = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  nmcu_writeback_if.master         wb,
  inout  wire  [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus
);
  localparam int DW = $clog2(MAX_INPUT_DIM) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WRITE  = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                   state;
  state_t                   state_nxt;

  logic [DW-1:0]            w_q;
  logic [DW-1:0]            h_q;
  logic [DW-1:0]            fw_q;
  logic [DW-2:0]            row_q;
  logic [DW-2:0]            col_q;
  logic [DW-2:0]            rd_row_q;
  logic [DW-2:0]            rd_col_q;
  logic [ADDR_WIDTH-1:0]    adr_q;
  logic [DATABUS_WIDTH-1:0] data_q;
  logic                     last_q;

  logic                     col_more;
  logic                     row_more;
  logic                     drive_bus;

  // Index comparisons widened by one bit so they can be made against the DW-bit dimensions
  assign col_more  = ({1'b0, col_q} + DW'(1)) < w_q;
  assign row_more  = ({1'b0, row_q} + DW'(1)) < h_q;
  assign drive_bus = (state == S_WRITE);

  // Single-master bus: both buses float whenever no write is being presented
  assign address_bus = drive_bus ? adr_q  : {ADDR_WIDTH{1'bz}};
  assign data_bus    = drive_bus ? data_q : {DATABUS_WIDTH{1'bz}};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (wb.start) begin
          if ((wb.out_width == '0) || (wb.out_height == '0)) state_nxt = S_FINISH;
          else                                               state_nxt = S_FETCH;
        end
      end
      S_FETCH:  state_nxt = S_WRITE;
      S_WRITE:  if (wb.ready) state_nxt = S_GAP;
      S_GAP:    state_nxt = last_q ? S_FINISH : S_FETCH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs; read indices follow the walk only during FETCH and hold otherwise
  always_comb begin
    wb.busy    = (state != S_IDLE);
    wb.done    = (state == S_FINISH);
    wb.mem_sel = (state == S_WRITE);
    wb.mem_w   = (state == S_WRITE);
    wb.rd_row  = (state == S_FETCH) ? row_q : rd_row_q;
    wb.rd_col  = (state == S_FETCH) ? col_q : rd_col_q;
  end

  // Datapath: latch the job, capture buffer words, walk the cone and its strided addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q      <= '0;
      h_q      <= '0;
      fw_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      rd_row_q <= '0;
      rd_col_q <= '0;
      adr_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wb.start) begin
            w_q    <= wb.out_width;
            h_q    <= wb.out_height;
            fw_q   <= wb.full_output_width;
            row_q  <= '0;
            col_q  <= '0;
            adr_q  <= wb.output_addr;
            last_q <= 1'b0;
          end
        end
        S_FETCH: begin
          rd_row_q <= row_q;
          rd_col_q <= col_q;
`ifdef NMCU_WB_FUSED_RELU_EN
          data_q   <= wb.rd_data[DATABUS_WIDTH-1] ? '0 : wb.rd_data;
`else
          data_q   <= wb.rd_data;
`endif
        end
        S_WRITE: begin
          if (wb.ready) begin
            if (col_more) begin
              col_q <= col_q + 1'b1;
              adr_q <= adr_q + ADDR_WIDTH'(1);
            end else if (row_more) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
              // Jump from the cone's last column to column 0 of the next full-map row
              adr_q <= adr_q + ADDR_WIDTH'(fw_q) - ADDR_WIDTH'(w_q) + ADDR_WIDTH'(1);
            end else begin
              last_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nmcu_writeback.sv
// tb/tb_nmcu_writeback.sv - self-checking bench for nmcu_writeback against a cone-walk reference model
module tb_nmcu_writeback;
  localparam int AW   = 16;
  localparam int DWID = 32;
  localparam int DW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nmcu_writeback_if #(.ADDR_WIDTH(AW), .DATABUS_WIDTH(DWID), .DW(DW)) ifc ();
  wire [AW-1:0]   address_bus;
  wire [DWID-1:0] data_bus;

  nmcu_writeback #(.ADDR_WIDTH(AW), .DATABUS_WIDTH(DWID), .MAX_INPUT_DIM(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (ifc.master),
    .address_bus (address_bus),
    .data_bus    (data_bus)
  );

  // Local activation buffer model: combinational read
  logic [DWID-1:0] bufm [0:15][0:15];
  assign ifc.rd_data = bufm[ifc.rd_row][ifc.rd_col];

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [DWID-1:0] model_word(input logic [DWID-1:0] x);
`ifdef NMCU_WB_FUSED_RELU_EN
    if ($signed(x) < 0) return '0;
`endif
    return x;
  endfunction

  typedef struct {
    logic [AW-1:0]   a;
    logic [DWID-1:0] d;
  } wr_t;

  wr_t got[$];
  wr_t exp_q[$];
  int  holds[$];
  int  cyc = 0;
  int  busy_cnt, stalls, gap_viol, sel_cnt, unstable, hold;
  logic [AW-1:0] hold_addr;
  logic prev_commit;
  int  ready_mode;
  int  low_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle: a write commits at the next edge unless reset wins
  always @(negedge clk) begin
    if (!rst && ifc.mem_sel && ifc.mem_w && ifc.ready)
      got.push_back('{a: address_bus, d: data_bus});
    if (prev_commit && ifc.mem_sel) gap_viol <= gap_viol + 1;
    prev_commit <= !rst && ifc.mem_sel && ifc.mem_w && ifc.ready;
    if (ifc.busy) busy_cnt <= busy_cnt + 1;
    if (ifc.mem_sel) begin
      sel_cnt <= sel_cnt + 1;
      if (!ifc.ready) stalls <= stalls + 1;
      if (hold == 0) hold_addr <= address_bus;
      else if (address_bus != hold_addr) unstable <= unstable + 1;
      hold <= hold + 1;
    end else if (hold != 0) begin
      holds.push_back(hold);
      hold <= 0;
    end
  end

  // Memory ready driver
  initial begin
    ifc.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: ifc.ready = ($urandom % 4) != 0;
        2: begin
          if (ifc.mem_sel && low_cnt < 4) begin
            ifc.ready = 1'b0;
            low_cnt++;
          end else begin
            ifc.ready = 1'b1;
          end
        end
        default: ifc.ready = 1'b1;
      endcase
    end
  end

  task automatic clear_mon();
    got.delete();
    holds.delete();
    busy_cnt = 0; stalls = 0; gap_viol = 0; sel_cnt = 0; unstable = 0; hold = 0;
    prev_commit = 1'b0;
    low_cnt = 0;
  endtask

  task automatic build_expect(input logic [AW-1:0] oa, input int w, input int h, input int fw);
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back('{a: AW'(int'(oa) + r * fw + c), d: model_word(bufm[r][c])});
  endtask

  task automatic issue_start(input logic [AW-1:0] oa, input int w, input int h, input int fw, output int acc);
    ifc.start = 1'b1;
    ifc.output_addr = oa;
    ifc.out_width = DW'(w);
    ifc.out_height = DW'(h);
    ifc.full_output_width = DW'(fw);
    @(posedge clk);
    #1;
    acc = cyc;
    ifc.start = 1'b0;
    // Inputs are latched at acceptance; scramble them to prove it
    ifc.output_addr = AW'($urandom);
    ifc.out_width = DW'($urandom);
    ifc.out_height = DW'($urandom);
    ifc.full_output_width = DW'($urandom);
  endtask

  task automatic run_cone(input logic [AW-1:0] oa, input int w, input int h, input int fw,
                          input int rmode, input bit rnd, input string nm);
    int acc, done_cyc, lat;
    bit seen;
    if (rnd)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) bufm[r][c] = $urandom;
    build_expect(oa, w, h, fw);
    ready_mode = rmode;
    clear_mon();
    issue_start(oa, w, h, fw, acc);
    seen = 1'b0;
    done_cyc = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (ifc.done) begin
        done_cyc = cyc;
        seen = 1'b1;
        break;
      end
    end
    check({nm, " done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    check({nm, " done_one_cycle"}, 64'(ifc.done), 64'd0);
    check({nm, " idle_after"}, 64'(ifc.busy), 64'd0);
    lat = done_cyc - (acc - 1);
    check({nm, " latency"}, 64'(lat), 64'(3 * w * h + 1 + stalls));
    check({nm, " busy_cycles"}, 64'(busy_cnt), 64'(lat));
    if (rmode == 0) check({nm, " no_stalls"}, 64'(stalls), 64'd0);
    check({nm, " gap_after_write"}, 64'(gap_viol), 64'd0);
    check({nm, " addr_stable"}, 64'(unstable), 64'd0);
    check({nm, " commits"}, 64'(got.size()), 64'(exp_q.size()));
    if (exp_q.size() == 0) check({nm, " no_mem_sel"}, 64'(sel_cnt), 64'd0);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      if (got[i].a !== exp_q[i].a) check($sformatf("%s addr[%0d]", nm, i), 64'(got[i].a), 64'(exp_q[i].a));
      else checks++;
      if (got[i].d !== exp_q[i].d) check($sformatf("%s data[%0d]", nm, i), 64'(got[i].d), 64'(exp_q[i].d));
      else checks++;
    end
  endtask

  typedef struct {
    logic [AW-1:0] oa;
    int            w, h, fw, rmode;
    logic [AW-1:0] first_a, last_a;
    int            n;
    string         nm;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'h0100,  2,  2,  5, 0, 16'h0100, 16'h0106,   4, "cone2x2"};
    tbl[1] = '{16'h0200,  3,  1,  8, 2, 16'h0200, 16'h0202,   3, "stall1x3"};
    tbl[2] = '{16'h0300,  0,  3,  5, 0, 16'h0000, 16'h0000,   0, "zero_w"};
    tbl[3] = '{16'h0400,  3,  0,  5, 0, 16'h0000, 16'h0000,   0, "zero_h"};
    tbl[4] = '{16'hFFFF,  2,  1,  4, 0, 16'hFFFF, 16'h0000,   2, "wrap"};
    tbl[5] = '{16'h0500,  4,  3,  2, 1, 16'h0500, 16'h0507,  12, "narrow_fw"};
    tbl[6] = '{16'h0600,  3,  3, 15, 1, 16'h0600, 16'h0620,   9, "rand3x3"};
    tbl[7] = '{16'h0700, 15, 15, 15, 1, 16'h0700, 16'h07E0, 225, "max"};

    ready_mode = 0;
    clear_mon();
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.output_addr = '0;
    ifc.out_width = '0;
    ifc.out_height = '0;
    ifc.full_output_width = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) bufm[r][c] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(ifc.busy), 64'd0);
    check("rst done", 64'(ifc.done), 64'd0);
    check("rst mem_sel", 64'(ifc.mem_sel), 64'd0);
    check("rst mem_w", 64'(ifc.mem_w), 64'd0);
    check("rst rd_row", 64'(ifc.rd_row), 64'd0);
    check("rst rd_col", 64'(ifc.rd_col), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_cone(tbl[i].oa, tbl[i].w, tbl[i].h, tbl[i].fw, tbl[i].rmode, 1'b1, tbl[i].nm);
      check({tbl[i].nm, " n"}, 64'(got.size()), 64'(tbl[i].n));
      if (tbl[i].n > 0 && got.size() > 0) begin
        check({tbl[i].nm, " first_addr"}, 64'(got[0].a), 64'(tbl[i].first_a));
        check({tbl[i].nm, " last_addr"}, 64'(got[got.size()-1].a), 64'(tbl[i].last_a));
      end
      if (tbl[i].rmode == 2 && holds.size() > 0)
        check({tbl[i].nm, " first_hold"}, 64'(holds[0]), 64'd5);
    end

    // Randomized cones against the reference model
    for (int k = 0; k < 8; k++) begin
      run_cone(AW'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 15)), 1, 1'b1, $sformatf("rand%0d", k));
    end

    // Fused ReLU boundary words
    bufm[0][0] = 32'hFFFF_FFF6;
    bufm[0][1] = 32'h0000_0007;
    run_cone(16'h0A00, 2, 1, 4, 0, 1'b0, "relu");
    if (got.size() == 2) begin
`ifdef NMCU_WB_FUSED_RELU_EN
      check("relu neg word", 64'(got[0].d), 64'h0);
`else
      check("relu neg word", 64'(got[0].d), 64'hFFFF_FFF6);
`endif
      check("relu pos word", 64'(got[1].d), 64'h7);
    end

    // Reset during the write of element 3 of a 3x3 cone
    begin
      int acc;
      bit hit;
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) bufm[r][c] = $urandom;
      build_expect(16'h0800, 3, 3, 3);
      ready_mode = 0;
      clear_mon();
      issue_start(16'h0800, 3, 3, 3, acc);
      hit = 1'b0;
      for (int n = 0; n < 100; n++) begin
        if (got.size() == 2 && ifc.mem_sel) begin
          hit = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      check("midrst reached_write3", 64'(hit), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst mem_sel", 64'(ifc.mem_sel), 64'd0);
      check("midrst mem_w", 64'(ifc.mem_w), 64'd0);
      check("midrst busy", 64'(ifc.busy), 64'd0);
      check("midrst done", 64'(ifc.done), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst commits", 64'(got.size()), 64'd2);
      if (got.size() == 2) begin
        check("midrst addr1", 64'(got[1].a), 64'(exp_q[1].a));
        check("midrst data1", 64'(got[1].d), 64'(exp_q[1].d));
      end
      @(posedge clk);
      #1;
      run_cone(16'h0900, 2, 2, 6, 0, 1'b1, "after_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
